// File: rtl/sme_feeder_pkg.sv
// Shared SME parameters and the feeder's FSM state type.
package sme_feeder_pkg;

  // Character and buffer geometry, shared with the string-match engine.
  localparam int BYTE        = 8;
  localparam int MAX_STRING  = 32;
  localparam int MAX_PATTERN = 8;
  localparam int STR_ADD     = $clog2(MAX_STRING);
  localparam int PAT_ADD     = $clog2(MAX_PATTERN);

  // Result wait budget, held in an 8-bit counter.
  localparam int TIMEOUT = 255;
  localparam int WAIT_W  = 8;

  // Feeder job phases.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND_STR = 2'd1,
    ST_SEND_PAT = 2'd2,
    ST_WAIT     = 2'd3
  } state_e;

endpackage

// File: rtl/sme_char_buf.sv
// Append-only character buffer: DEPTH x BYTE storage, length counter,
// full flag and an asynchronous random read port. clear empties the
// buffer before a same-cycle write, so that write lands at index 0.
module sme_char_buf
  import sme_feeder_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int ADD   = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            wr_en,
  input  logic [BYTE-1:0] wr_data,
  input  logic [ADD-1:0]  rd_addr,
  output logic [ADD:0]    len,
  output logic            full,
  output logic [BYTE-1:0] rd_data
);

  localparam logic [ADD:0] DEPTH_L = (ADD+1)'(DEPTH);

  logic [BYTE-1:0] mem_q [DEPTH];
  logic [ADD:0]    len_q, len_d;
  logic [ADD:0]    base;
  logic            wr_ok;

  // Length after an optional clear, then the append if there is room.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
    base  = clear ? '0 : len_q;
    wr_ok = wr_en && (base != DEPTH_L);
    len_d = wr_ok ? base + 1'b1 : base;
  end

  // Length register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) len_q <= '0;
    else        len_q <= len_d;
  end

  // Character storage.
  // NOTE: storage is deliberately not reset; len_q alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[base[ADD-1:0]] <= wr_data;
  end

  assign len     = len_q;
  assign full    = (len_q == DEPTH_L);
  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/sme_feeder.sv
// Transmit-side driver for the SME string-match engine. Streams the
// buffered string and pattern on chardata with isstring/ispattern,
// then waits for the engine's result or abandons the job on timeout.
module sme_feeder
  import sme_feeder_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic               wr_sel,
  input  logic [BYTE-1:0]    wr_data,
  input  logic               clear,
  input  logic               start,
  input  logic               reuse_str,
  output logic               busy,
  output logic               overflow,
  output logic [BYTE-1:0]    chardata,
  output logic               isstring,
  output logic               ispattern,
  input  logic               sme_valid,
  input  logic               sme_match,
  input  logic [STR_ADD-1:0] sme_match_idx,
  output logic               res_valid,
  output logic               res_match,
  output logic [STR_ADD-1:0] res_index,
  output logic               res_timeout
);

  localparam int PTR_W = STR_ADD + 1;
  // wait_cnt counts WAIT cycles from 0. WAIT starts one cycle after the last
  // strobe and the result flop adds one more, so abandoning at TIMEOUT-2
  // puts the timeout pulse exactly TIMEOUT cycles after the last strobe.
  localparam logic [WAIT_W-1:0] TIMEOUT_LAST = WAIT_W'(TIMEOUT - 2);

  state_e               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic                 str_sent_q, str_sent_d;
  logic                 overflow_q, overflow_d;
  logic [BYTE-1:0]      chardata_q, chardata_d;
  logic                 isstring_q, isstring_d;
  logic                 ispattern_q, ispattern_d;
  logic                 res_valid_q, res_valid_d;
  logic                 res_match_q, res_match_d;
  logic [STR_ADD-1:0]   res_index_q, res_index_d;
  logic                 res_timeout_q, res_timeout_d;

  logic                 host_ok, start_ok, job_end;
  logic                 str_clear, str_wr, pat_clear, pat_wr;
  logic [STR_ADD-1:0]   str_rd_addr;
  logic [PAT_ADD-1:0]   pat_rd_addr;
  logic [STR_ADD:0]     str_len;
  logic [PAT_ADD:0]     pat_len;
  logic                 str_full, pat_full;
  logic [BYTE-1:0]      str_rd_data, pat_rd_data;

  // Host requests are honoured only while idle, including not in the result cycle.
  assign host_ok  = (state_q == ST_IDLE) && !res_valid_q;
  assign start_ok = host_ok && start && !clear && (pat_len != '0) &&
                    (reuse_str ? str_sent_q : (str_len != '0));

  assign str_clear = host_ok && clear;
  assign str_wr    = host_ok && wr_en && !wr_sel;
  assign pat_clear = (host_ok && clear) || job_end;
  assign pat_wr    = host_ok && wr_en && wr_sel;

  // Read addresses follow the pointer only in the phase reading that buffer;
  // otherwise they sit at 0, ready for the first character of the next phase.
  always_comb begin
    str_rd_addr = '0;
    pat_rd_addr = '0;
    if (state_q == ST_SEND_STR) str_rd_addr = ptr_q[STR_ADD-1:0];
    if (state_q == ST_SEND_PAT) pat_rd_addr = ptr_q[PAT_ADD-1:0];
  end

  sme_char_buf #(.DEPTH(MAX_STRING), .ADD(STR_ADD)) u_str_buf (
    .clk     (clk),
    .reset   (reset),
    .clear   (str_clear),
    .wr_en   (str_wr),
    .wr_data (wr_data),
    .rd_addr (str_rd_addr),
    .len     (str_len),
    .full    (str_full),
    .rd_data (str_rd_data)
  );

  sme_char_buf #(.DEPTH(MAX_PATTERN), .ADD(PAT_ADD)) u_pat_buf (
    .clk     (clk),
    .reset   (reset),
    .clear   (pat_clear),
    .wr_en   (pat_wr),
    .wr_data (wr_data),
    .rd_addr (pat_rd_addr),
    .len     (pat_len),
    .full    (pat_full),
    .rd_data (pat_rd_data)
  );

  // Next-state, registered strobe values and result capture.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    wait_cnt_d    = wait_cnt_q;
    str_sent_d    = str_sent_q;
    overflow_d    = overflow_q;
    chardata_d    = '0;
    isstring_d    = 1'b0;
    ispattern_d   = 1'b0;
    res_valid_d   = 1'b0;
    res_match_d   = res_match_q;
    res_index_d   = res_index_q;
    res_timeout_d = res_timeout_q;
    job_end       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (host_ok) begin
          if (clear) begin
            str_sent_d = 1'b0;
            overflow_d = 1'b0;
          end else if (wr_en && (wr_sel ? pat_full : str_full)) begin
            overflow_d = 1'b1;
          end
          if (start_ok) begin
            ptr_d = PTR_W'(1);
            if (reuse_str) begin
              state_d     = ST_SEND_PAT;
              ispattern_d = 1'b1;
              chardata_d  = pat_rd_data;
            end else begin
              state_d    = ST_SEND_STR;
              isstring_d = 1'b1;
              chardata_d = str_rd_data;
            end
          end
        end
      end

      ST_SEND_STR: begin
        if (ptr_q < str_len) begin
          isstring_d = 1'b1;
          chardata_d = str_rd_data;
          ptr_d      = ptr_q + 1'b1;
        end else begin
          state_d     = ST_SEND_PAT;
          ispattern_d = 1'b1;
          chardata_d  = pat_rd_data;
          ptr_d       = PTR_W'(1);
        end
      end

      ST_SEND_PAT: begin
        if (ptr_q < PTR_W'(pat_len)) begin
          ispattern_d = 1'b1;
          chardata_d  = pat_rd_data;
          ptr_d       = ptr_q + 1'b1;
        end else begin
          state_d    = ST_WAIT;
          wait_cnt_d = '0;
          str_sent_d = 1'b1;
        end
      end

      ST_WAIT: begin
        wait_cnt_d = wait_cnt_q + 1'b1;
        if (sme_valid) begin
          state_d       = ST_IDLE;
          job_end       = 1'b1;
          res_valid_d   = 1'b1;
          res_match_d   = sme_match;
          res_index_d   = sme_match_idx;
          res_timeout_d = 1'b0;
        end else if (wait_cnt_q == TIMEOUT_LAST) begin
          state_d       = ST_IDLE;
          job_end       = 1'b1;
          res_valid_d   = 1'b1;
          res_match_d   = 1'b0;
          res_index_d   = '0;
          res_timeout_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State, pointer, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      wait_cnt_q    <= '0;
      str_sent_q    <= 1'b0;
      overflow_q    <= 1'b0;
      chardata_q    <= '0;
      isstring_q    <= 1'b0;
      ispattern_q   <= 1'b0;
      res_valid_q   <= 1'b0;
      res_match_q   <= 1'b0;
      res_index_q   <= '0;
      res_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      wait_cnt_q    <= wait_cnt_d;
      str_sent_q    <= str_sent_d;
      overflow_q    <= overflow_d;
      chardata_q    <= chardata_d;
      isstring_q    <= isstring_d;
      ispattern_q   <= ispattern_d;
      res_valid_q   <= res_valid_d;
      res_match_q   <= res_match_d;
      res_index_q   <= res_index_d;
      res_timeout_q <= res_timeout_d;
    end
  end

  assign busy        = (state_q != ST_IDLE) || res_valid_q;
  assign overflow    = overflow_q;
  assign chardata    = chardata_q;
  assign isstring    = isstring_q;
  assign ispattern   = ispattern_q;
  assign res_valid   = res_valid_q;
  assign res_match   = res_match_q;
  assign res_index   = res_index_q;
  assign res_timeout = res_timeout_q;

endmodule

// File: tb/tb_sme_feeder.sv
// Self-checking bench for sme_feeder: directed scenarios plus randomized
// jobs, all compared against a queue-based model of the host buffers and
// a behavioural string-match model standing in for the SME.
module tb_sme_feeder;
  import sme_feeder_pkg::*;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               wr_en = 1'b0, wr_sel = 1'b0, clear = 1'b0;
  logic               start = 1'b0, reuse_str = 1'b0;
  logic [BYTE-1:0]    wr_data = '0;
  logic               busy, overflow, isstring, ispattern;
  logic [BYTE-1:0]    chardata;
  logic               sme_valid = 1'b0, sme_match = 1'b0;
  logic [STR_ADD-1:0] sme_match_idx = '0;
  logic               res_valid, res_match, res_timeout;
  logic [STR_ADD-1:0] res_index;

  sme_feeder dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .clear(clear), .start(start), .reuse_str(reuse_str), .busy(busy),
    .overflow(overflow), .chardata(chardata), .isstring(isstring),
    .ispattern(ispattern), .sme_valid(sme_valid), .sme_match(sme_match),
    .sme_match_idx(sme_match_idx), .res_valid(res_valid), .res_match(res_match),
    .res_index(res_index), .res_timeout(res_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model of host-visible state.
  logic [7:0] str_m[$];
  logic [7:0] pat_m[$];
  bit         ovf_m  = 1'b0;
  bit         sent_m = 1'b0;
  bit         last_match_m = 1'b0;
  int         last_idx_m = 0;
  bit         last_to_m = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_clear();
    str_m.delete();
    pat_m.delete();
    ovf_m  = 1'b0;
    sent_m = 1'b0;
  endfunction

  // Engine behaviour: find the pattern in the string; a leading '^' anchors it at 0.
  function automatic void sme_model(output bit m, output int idx);
    int  a, plen, last;
    bit  ok;
    m = 1'b0;
    idx = 0;
    a = (pat_m.size() > 0 && pat_m[0] == 8'h5e) ? 1 : 0;
    plen = pat_m.size() - a;
    last = a ? 0 : str_m.size() - plen;
    for (int p = 0; p <= last && !m; p++) begin
      ok = (p + plen <= str_m.size());
      for (int k = 0; k < plen && ok; k++)
        if (str_m[p+k] != pat_m[a+k]) ok = 1'b0;
      if (ok) begin
        m = 1'b1;
        idx = p;
      end
    end
  endfunction

  task automatic host_write(input logic sel, input logic [7:0] d, input logic with_clear = 1'b0);
    wr_en = 1'b1; wr_sel = sel; wr_data = d; clear = with_clear;
    tick();
    wr_en = 1'b0; clear = 1'b0;
    if (with_clear) model_clear();
    if (sel) begin
      if (pat_m.size() == MAX_PATTERN) ovf_m = 1'b1; else pat_m.push_back(d);
    end else begin
      if (str_m.size() == MAX_STRING) ovf_m = 1'b1; else str_m.push_back(d);
    end
  endtask

  task automatic host_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_clear();
  endtask

  task automatic write_text(input logic sel, input string s);
    for (int i = 0; i < s.len(); i++) host_write(sel, s[i]);
  endtask

  // A start the model says must be refused: nothing moves, no result.
  task automatic refused_start(input string tag, input bit reuse);
    start = 1'b1; reuse_str = reuse;
    tick();
    start = 1'b0; reuse_str = 1'b0;
    check({tag, "_busy"}, busy, 0);
    check({tag, "_strobes"}, {isstring, ispattern}, 0);
    tick();
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_busy2"}, busy, 0);
  endtask

  // Run one job. timeout=1: the SME never answers; otherwise it answers
  // 'delay' cycles into WAIT. poke drives illegal host traffic mid-stream.
  task automatic run_job(input bit reuse, input bit timeout, input int delay, input bit poke);
    logic [7:0] exp_q[$];
    bit  m;
    int  idx, t, ns;
    bit  is_str;
    exp_q.delete();
    ns = reuse ? 0 : str_m.size();
    if (!reuse) foreach (str_m[i]) exp_q.push_back(str_m[i]);
    foreach (pat_m[i]) exp_q.push_back(pat_m[i]);
    sme_model(m, idx);

    start = 1'b1; reuse_str = reuse;
    tick();
    start = 1'b0; reuse_str = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      is_str = (k < ns);
      check("isstring", isstring, is_str);
      check("ispattern", ispattern, !is_str);
      check("chardata", chardata, exp_q[k]);
      check("busy_stream", busy, 1);
      if (poke && k == 0) begin
        start = 1'b1; wr_en = 1'b1; wr_sel = 1'b1; wr_data = 8'h5a; clear = 1'b1; sme_valid = 1'b1;
      end
      tick();
      start = 1'b0; wr_en = 1'b0; clear = 1'b0; sme_valid = 1'b0;
    end
    check("wait_strobes", {isstring, ispattern}, 0);
    check("wait_chardata", chardata, 0);
    check("wait_busy", busy, 1);

    if (timeout) begin
      t = 1;
      while (res_valid !== 1'b1 && t < 400) begin
        tick();
        t++;
      end
      check("timeout_latency", t, TIMEOUT);
      m = 1'b0; idx = 0;
    end else begin
      for (int j = 0; j < delay; j++) begin
        if (j % 16 == 0) check("no_early_result", res_valid, 0);
        tick();
      end
      sme_valid = 1'b1; sme_match = m; sme_match_idx = idx[STR_ADD-1:0];
      tick();
      sme_valid = 1'b0; sme_match = 1'b0; sme_match_idx = '0;
    end
    check("res_valid", res_valid, 1);
    check("res_match", res_match, m);
    check("res_index", res_index, idx);
    check("res_timeout", res_timeout, timeout);
    check("busy_result", busy, 1);
    tick();
    check("res_valid_pulse", res_valid, 0);
    check("busy_after", busy, 0);
    check("res_match_held", res_match, m);
    check("res_index_held", res_index, idx);
    pat_m.delete();
    sent_m = 1'b1;
    last_match_m = m; last_idx_m = idx; last_to_m = timeout;
  endtask

  function automatic logic [7:0] rand_char();
    return 8'h41 + 8'($urandom_range(0, 2));
  endfunction

  task automatic random_jobs(input int n);
    bit reuse;
    int ns, np;
    for (int it = 0; it < n; it++) begin
      reuse = sent_m && ($urandom_range(0, 1) == 1);
      if (!reuse) begin
        ns = $urandom_range(1, 10);
        host_write(1'b0, rand_char(), 1'b1);
        for (int i = 1; i < ns; i++) host_write(1'b0, rand_char());
      end
      np = $urandom_range(1, 4);
      if ($urandom_range(0, 3) == 0) host_write(1'b1, 8'h5e);
      for (int i = 0; i < np; i++) host_write(1'b1, rand_char());
      run_job(reuse, 1'b0, $urandom_range(0, 15), 1'b0);
    end
  endtask

  initial begin
    // Reset state.
    repeat (3) tick();
    check("rst_outputs", {busy, overflow, chardata, isstring, ispattern,
                          res_valid, res_match, res_index, res_timeout}, 0);
    reset = 1'b1;
    tick();

    // Basic job: string "ABCDE", pattern "CD" -> match at 2.
    write_text(1'b0, "ABCDE");
    write_text(1'b1, "CD");
    run_job(1'b0, 1'b0, 3, 1'b0);
    check("t1_match", res_match, 1);
    check("t1_index", res_index, 2);

    // Reuse the sent string with an anchored pattern that cannot match.
    write_text(1'b1, "^B");
    run_job(1'b1, 1'b0, 0, 1'b0);
    check("t2_match", res_match, 0);

    // Refused starts and a stray engine strobe while idle.
    refused_start("nopat_reuse", 1'b1);
    refused_start("nopat_fresh", 1'b0);
    sme_valid = 1'b1; sme_match = 1'b1; sme_match_idx = 5'd7;
    tick();
    sme_valid = 1'b0; sme_match = 1'b0; sme_match_idx = '0;
    check("stray_valid", res_valid, 0);
    check("stray_match", res_match, last_match_m);
    check("stray_index", res_index, last_idx_m);

    // Start, write and clear while busy are all dropped.
    write_text(1'b1, "AB");
    run_job(1'b1, 1'b0, 2, 1'b1);
    refused_start("busy_poke_dropped", 1'b1);

    // Engine never answers.
    write_text(1'b1, "Q");
    run_job(1'b1, 1'b1, 0, 1'b0);

    // Engine answers on the same cycle the timeout would fire.
    write_text(1'b1, "C");
    run_job(1'b1, 1'b0, TIMEOUT - 2, 1'b0);

    // Overflow: 33 string writes keep 32 chars and set the sticky flag.
    host_clear();
    check("ovf_cleared", overflow, 0);
    for (int i = 0; i < MAX_STRING + 1; i++) host_write(1'b0, 8'h41 + 8'(i % 26));
    check("ovf_set", overflow, ovf_m);
    write_text(1'b1, "A");
    run_job(1'b0, 1'b0, 1, 1'b0);
    check("ovf_sticky", overflow, 1);
    host_clear();
    check("ovf_clear", overflow, 0);
    write_text(1'b1, "A");
    refused_start("empty_str_fresh", 1'b0);
    refused_start("empty_str_reuse", 1'b1);

    // Clear together with a write: the byte lands at index 0 of an empty buffer.
    host_write(1'b0, 8'h58, 1'b1);
    write_text(1'b1, "X");
    run_job(1'b0, 1'b0, 0, 1'b0);
    check("clear_wr_match", res_match, 1);

    // Randomized jobs.
    random_jobs(10);

    // Reset mid-string aborts at once.
    host_clear();
    write_text(1'b0, "HELLO");
    write_text(1'b1, "LL");
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("pre_abort_isstring", isstring, 1);
    reset = 1'b0;
    #1;
    check("abort_outputs", {busy, overflow, chardata, isstring, ispattern,
                            res_valid, res_match, res_index, res_timeout}, 0);
    tick();
    reset = 1'b1;
    model_clear();
    tick();
    check("post_abort_res", res_valid, 0);
    write_text(1'b1, "L");
    refused_start("post_abort_reuse", 1'b1);
    refused_start("post_abort_fresh", 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
